ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single data RAM between two requesters: the CPU controller (port A, "cpu") and the program/debug loader (port B, "ldr").
- Sequences every RAM access as a fixed 4-state transaction with round-robin arbitration.
- Supports an optional loader lock for back-to-back bursts.
- Sits between the controller/datapath and the RAM; it is the only block that drives the RAM control pins.

Parameters:
AW, 8, address width
DW, 8, data width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request, level, held until cpu_done
cpu_we  in  1  1=write, 0=read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  one-cycle pulse, CPU transaction accepted
cpu_done  out  1  one-cycle pulse, CPU transaction complete
ldr_req  in  1  loader request, level
ldr_we  in  1  1=write, 0=read
ldr_addr  in  AW  loader address
ldr_wdata  in  DW  loader write data
ldr_lock  in  1  loader holds bus across consecutive requests
ldr_gnt  out  1  one-cycle pulse, loader transaction accepted
ldr_done  out  1  one-cycle pulse, loader transaction complete
rd_data  out  DW  read data, valid in the cycle done pulses for a read
ram_ena  out  1  RAM enable
ram_read  out  1  RAM read strobe
ram_write  out  1  RAM write strobe
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, registered, 1-cycle latency after ram_read

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous, active-low.
- Outputs: all outputs are registered.
- Reset state:
  - state = IDLE; last_owner = LDR, so the CPU wins the first tie.
  - All strobes, gnt and done = 0.
  - ram_addr, ram_wdata and rd_data = 0.
  - owner = CPU.
- States: IDLE -> ACC -> WAIT -> RESP -> IDLE.
- IDLE, arbitration on the sampled requests:
  - Only one requester asserted: that requester wins.
  - Both asserted: the requester that is not last_owner wins.
  - Lock override: if ldr_lock=1 and last_owner=LDR, the loader wins whenever ldr_req=1.
  - Winner's we/addr/wdata are latched into the transaction registers.
  - owner := winner; its gnt pulses in the next cycle; go to ACC.
  - No request: stay in IDLE.
- ACC (1 cycle):
  - ram_ena=1, ram_addr and ram_wdata driven from the latched values.
  - ram_read = !we, ram_write = we.
  - gnt of the owner = 1 in this cycle only.
- WAIT (1 cycle):
  - Strobes = 0.
  - For a read, ram_rdata is captured into rd_data at the end of WAIT.
- RESP (1 cycle):
  - done of the owner = 1.
  - rd_data is held from the capture (unchanged for writes).
  - last_owner := owner; go to IDLE.
- Latency:
  - req seen at edge N -> gnt at N+1 -> done at N+3.
  - Next grant is no earlier than N+5, so throughput is 1 transaction per 4 cycles.
- Request handling:
  - Requester inputs are don't-care after grant.
  - A req dropped mid-transaction does not abort: the transaction completes and done still pulses.
  - A requester must deassert req in the cycle after done unless it wants another access.
  - A req still high in IDLE is treated as a new request.
- Fairness:
  - Without lock, neither requester waits more than one transaction.
  - With ldr_lock held high, the CPU starves until lock drops. Lock is sampled only in IDLE; deasserting it mid-transaction has no effect on the current transaction.
- Mutual exclusion: ram_read and ram_write are never both 1; gnt/done are never asserted for both ports in the same cycle.
- Reset mid-transaction: immediately forces the reset state, with all strobes low the same instant. No done is issued for the aborted access.
- Widths: no arithmetic; addresses and data pass through unmodified.

Test Plan:
- Reset release, cpu_req=1, cpu_we=0, cpu_addr=0x12, ram returns 0xA5:
  - cpu_gnt at cycle 1, ram_read=1 with addr 0x12 in cycle 1.
  - cpu_done and rd_data=0xA5 at cycle 3.
- Both requests raised in the same cycle from reset:
  - CPU granted first; then loader, with ldr_gnt 4 cycles after cpu_gnt.
  - Continued simultaneous requests alternate CPU/LDR.
- Loader write, ldr_we=1, addr 0x40, wdata 0x3C:
  - ram_write=1, ram_addr=0x40, ram_wdata=0x3C for exactly 1 cycle.
  - ldr_done 2 cycles later; rd_data unchanged.
- ldr_lock=1 with ldr_req and cpu_req continuously high:
  - After the first loader grant, only loader grants occur.
  - Dropping lock gives the CPU the very next grant.
- cpu_req dropped in the cycle after cpu_gnt:
  - The transaction still completes, and cpu_done pulses at gnt+2.
- rst asserted low during WAIT of a read:
  - All outputs are 0 immediately and no done pulse occurs.
  - After release, a pending ldr_req is granted 1 cycle later.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single data RAM between the CPU controller (cpu)
// and the program/debug loader (ldr). Each access is a fixed four-cycle
// transaction IDLE -> ACC -> WAIT -> RESP with round-robin arbitration and an
// optional loader lock that keeps the loader in control across bursts.
//
// Ports:
//   clk, rst                    clock and asynchronous active-low reset
//   cpu_req/we/addr/wdata       CPU request (level) and its access details
//   cpu_gnt, cpu_done           one-cycle accept / complete pulses to the CPU
//   ldr_req/we/addr/wdata/lock  loader request, access details and bus lock
//   ldr_gnt, ldr_done           one-cycle accept / complete pulses to the loader
//   rd_data                     read data, valid while done pulses for a read
//   ram_ena/read/write          RAM control strobes (only this block drives them)
//   ram_addr, ram_wdata         RAM address and write data
//   ram_rdata                   RAM read data, one cycle after ram_read
// All outputs are registered.
module ram_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic          ldr_lock,
  output logic          ldr_gnt,
  output logic          ldr_done,
  output logic [DW-1:0] rd_data,
  output logic          ram_ena,
  output logic          ram_read,
  output logic          ram_write,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  owner_t          last_q, last_d;
  logic            we_q, we_d;

  logic            ldr_win;
  logic            sel_we;
  logic            cpu_gnt_d, ldr_gnt_d, cpu_done_d, ldr_done_d;
  logic            ram_ena_d, ram_read_d, ram_write_d;
  logic [AW-1:0]   ram_addr_d;
  logic [DW-1:0]   ram_wdata_d;
  logic [DW-1:0]   rd_data_d;

  // State, transaction and output registers; reset drops every strobe at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_CPU;
      last_q    <= OWN_LDR;
      we_q      <= 1'b0;
      cpu_gnt   <= 1'b0;
      ldr_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      ldr_done  <= 1'b0;
      ram_ena   <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_data   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      cpu_gnt   <= cpu_gnt_d;
      ldr_gnt   <= ldr_gnt_d;
      cpu_done  <= cpu_done_d;
      ldr_done  <= ldr_done_d;
      ram_ena   <= ram_ena_d;
      ram_read  <= ram_read_d;
      ram_write <= ram_write_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      rd_data   <= rd_data_d;
    end
  end

  // Next-state and next-output logic. Outputs are computed one state ahead so
  // that the registered versions line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    cpu_gnt_d   = 1'b0;
    ldr_gnt_d   = 1'b0;
    cpu_done_d  = 1'b0;
    ldr_done_d  = 1'b0;
    ram_ena_d   = 1'b0;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    rd_data_d   = rd_data;

    // Loader wins when alone, when the CPU had the last turn, or when it
    // holds the lock after its own transaction.
    ldr_win = ldr_req && (!cpu_req || (last_q == OWN_CPU) || ldr_lock);
    sel_we  = ldr_win ? ldr_we : cpu_we;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req || ldr_req) begin
          state_d     = S_ACC;
          owner_d     = ldr_win ? OWN_LDR : OWN_CPU;
          we_d        = sel_we;
          ram_addr_d  = ldr_win ? ldr_addr : cpu_addr;
          ram_wdata_d = ldr_win ? ldr_wdata : cpu_wdata;
          ram_ena_d   = 1'b1;
          ram_read_d  = !sel_we;
          ram_write_d = sel_we;
          cpu_gnt_d   = !ldr_win;
          ldr_gnt_d   = ldr_win;
        end
      end
      S_ACC: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_RESP;
        if (!we_q) rd_data_d = ram_rdata;
        cpu_done_d = (owner_q == OWN_CPU);
        ldr_done_d = (owner_q == OWN_LDR);
      end
      S_RESP: begin
        state_d = S_IDLE;
        last_d  = owner_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [AW-1:0] cpu_addr, ldr_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata;
  logic          cpu_gnt, cpu_done, ldr_gnt, ldr_done;
  logic [DW-1:0] rd_data;
  logic          ram_ena, ram_read, ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_done(ldr_done),
    .rd_data(rd_data),
    .ram_ena(ram_ena), .ram_read(ram_read), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural RAM with registered read; ram_clear loads addr ^ 8'hB7.
  logic          ram_clear;
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hB7;
      ram_rdata <= '0;
    end else begin
      if (ram_ena && ram_write) mem[ram_addr] <= ram_wdata;
      if (ram_ena && ram_read) ram_rdata <= mem[ram_addr];
    end
  end

  // Transaction-level reference: ph counts cycles since the grant was taken
  // (0 = arbiter free). Memory contents are tracked independently.
  int            ph;
  bit            m_own_ldr, m_last_ldr, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd;
  logic [DW-1:0] ref_mem [256];

  task automatic model_reset();
    ph = 0; m_own_ldr = 1'b0; m_last_ldr = 1'b1; m_rd = '0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_step();
    bit pick_ldr;
    case (ph)
      0: if (cpu_req || ldr_req) begin
        if (cpu_req && ldr_req) pick_ldr = !m_last_ldr || (ldr_lock && m_last_ldr);
        else pick_ldr = ldr_req;
        m_own_ldr = pick_ldr;
        m_we    = pick_ldr ? ldr_we : cpu_we;
        m_addr  = pick_ldr ? ldr_addr : cpu_addr;
        m_wdata = pick_ldr ? ldr_wdata : cpu_wdata;
        ph = 1;
      end
      1: begin
        if (m_we) ref_mem[m_addr] = m_wdata;
        ph = 2;
      end
      2: begin
        if (!m_we) m_rd = ref_mem[m_addr];
        ph = 3;
      end
      default: begin
        m_last_ldr = m_own_ldr;
        ph = 0;
      end
    endcase
  endtask

  // Advance one clock: the model consumes the inputs the DUT is about to
  // sample, then the bench lands on the following falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 0;
  endtask

  task automatic settle();
    idle_inputs();
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({cpu_gnt, ldr_gnt, cpu_done, ldr_done, ram_ena, ram_read, ram_write} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {cpu_gnt, ldr_gnt, cpu_done, ldr_done, ram_ena, ram_read, ram_write});
    end
    checks++;
    if ({ram_addr, ram_wdata, rd_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h rd=%h want 0", ram_addr, ram_wdata, rd_data);
    end
  endtask

  task automatic test_cpu_read();
    rst = 1'b0;
    model_reset();
    idle_inputs();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h12;
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if ({cpu_gnt, ldr_gnt, ram_ena, ram_read, ram_write, ram_addr} !== {5'b10110, 8'h12}) begin
      errors++;
      $display("FAIL cpu_read_acc got gnt=%b ena=%b rd=%b wr=%b addr=%h want 1 1 1 0 12",
               cpu_gnt, ram_ena, ram_read, ram_write, ram_addr);
    end
    tick();
    checks++;
    if ({cpu_gnt, cpu_done, ram_ena, ram_read} !== 4'b0) begin
      errors++;
      $display("FAIL cpu_read_wait got gnt=%b done=%b ena=%b rd=%b want 0",
               cpu_gnt, cpu_done, ram_ena, ram_read);
    end
    tick();
    checks++;
    if (cpu_done !== 1'b1 || rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL cpu_read_done got done=%b rd_data=%h want 1 a5", cpu_done, rd_data);
    end
    cpu_req = 0;
    tick();
    checks++;
    if (cpu_done !== 1'b0 || rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL cpu_read_hold got done=%b rd_data=%h want 0 a5", cpu_done, rd_data);
    end
    settle();
  endtask

  task automatic test_both();
    rst = 1'b0;
    model_reset();
    idle_inputs();
    cpu_req = 1; ldr_req = 1; cpu_addr = 8'h01; ldr_addr = 8'h02;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (cpu_gnt !== 1'((i % 8) == 1) || ldr_gnt !== 1'((i % 8) == 5)) begin
        errors++;
        $display("FAIL both_alternate cyc=%0d got cpu_gnt=%b ldr_gnt=%b want %b %b",
                 i, cpu_gnt, ldr_gnt, (i % 8) == 1, (i % 8) == 5);
      end
    end
    settle();
  endtask

  task automatic test_ldr_write();
    logic [DW-1:0] rd_before;
    int wr_cnt, wr_cyc, done_cyc;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    rd_before = rd_data;
    wr_cnt = 0; wr_cyc = -1; done_cyc = -1; wr_addr = '0; wr_data = '0;
    ldr_req = 1; ldr_we = 1; ldr_addr = 8'h40; ldr_wdata = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ldr_gnt) ldr_req = 0;
      if (ram_write) begin
        wr_cnt++; wr_cyc = i; wr_addr = ram_addr; wr_data = ram_wdata;
      end
      if (ldr_done) done_cyc = i;
    end
    checks++;
    if (wr_cnt != 1 || wr_addr !== 8'h40 || wr_data !== 8'h3C) begin
      errors++;
      $display("FAIL ldr_write_strobe got cycles=%0d addr=%h data=%h want 1 40 3c",
               wr_cnt, wr_addr, wr_data);
    end
    checks++;
    if (done_cyc - wr_cyc != 2 || wr_cyc < 0) begin
      errors++;
      $display("FAIL ldr_write_done got write@%0d done@%0d want done 2 later", wr_cyc, done_cyc);
    end
    checks++;
    if (rd_data !== rd_before) begin
      errors++;
      $display("FAIL ldr_write_rd got %h want %h", rd_data, rd_before);
    end
    settle();
  endtask

  task automatic test_lock();
    bit seen_ldr, got;
    int cpu_after, ldr_cnt;
    seen_ldr = 0; cpu_after = 0; ldr_cnt = 0; got = 0;
    cpu_req = 1; ldr_req = 1; ldr_lock = 1; cpu_addr = 8'h10; ldr_addr = 8'h20;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (cpu_gnt && seen_ldr) cpu_after++;
      if (ldr_gnt) begin seen_ldr = 1; ldr_cnt++; end
    end
    checks++;
    if (cpu_after != 0 || ldr_cnt < 5) begin
      errors++;
      $display("FAIL lock_hold got cpu_grants=%0d ldr_grants=%0d want 0 >=5", cpu_after, ldr_cnt);
    end
    ldr_lock = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (cpu_gnt || ldr_gnt) begin
        got = 1;
        checks++;
        if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0) begin
          errors++;
          $display("FAIL lock_release got cpu_gnt=%b ldr_gnt=%b want 1 0", cpu_gnt, ldr_gnt);
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL lock_release_timeout got no grant want cpu_gnt");
    end
    settle();
  endtask

  task automatic test_drop();
    bit got;
    got = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h05; cpu_wdata = 8'h77;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = cpu_gnt;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL drop_timeout got no cpu_gnt want grant");
    end else begin
      cpu_req = 0;
      tick();
      checks++;
      if (cpu_done !== 1'b0) begin
        errors++;
        $display("FAIL drop_early_done got %b want 0", cpu_done);
      end
      tick();
      checks++;
      if (cpu_done !== 1'b1) begin
        errors++;
        $display("FAIL drop_done got %b want 1 at gnt+2", cpu_done);
      end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    bit got;
    got = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h12;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = cpu_gnt;
    end
    cpu_req = 0;
    tick();
    ldr_req = 1; ldr_we = 0; ldr_addr = 8'h33;
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({cpu_gnt, ldr_gnt, cpu_done, ldr_done, ram_ena, ram_read, ram_write} !== 7'b0 ||
        {ram_addr, ram_wdata, rd_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs got ctrl=%b addr=%h wdata=%h rd=%h want 0",
               {cpu_gnt, ldr_gnt, cpu_done, ldr_done, ram_ena, ram_read, ram_write},
               ram_addr, ram_wdata, rd_data);
    end
    @(negedge clk);
    checks++;
    if (cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %b want 0", cpu_done);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (ldr_gnt !== 1'b1 || cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_regrant got ldr_gnt=%b cpu_done=%b want 1 0", ldr_gnt, cpu_done);
    end
    ldr_req = 0;
    settle();
  endtask

  task automatic test_random();
    logic [6:0] exp_ctrl;
    bit acc, rsp;
    for (int n = 0; n < 800; n++) begin
      cpu_req   = ($urandom_range(0, 2) != 0);
      ldr_req   = ($urandom_range(0, 2) != 0);
      ldr_lock  = ($urandom_range(0, 3) == 0);
      cpu_we    = 1'($urandom_range(0, 1));
      ldr_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 8'($urandom_range(0, 15));
      ldr_addr  = 8'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom);
      ldr_wdata = 8'($urandom);
      tick();
      acc = (ph == 1);
      rsp = (ph == 3);
      exp_ctrl = {acc && !m_own_ldr, acc && m_own_ldr, rsp && !m_own_ldr, rsp && m_own_ldr,
                  acc, acc && !m_we, acc && m_we};
      checks++;
      if ({cpu_gnt, ldr_gnt, cpu_done, ldr_done, ram_ena, ram_read, ram_write} !== exp_ctrl) begin
        errors++;
        $display("FAIL rand_ctrl n=%0d got %b want %b", n,
                 {cpu_gnt, ldr_gnt, cpu_done, ldr_done, ram_ena, ram_read, ram_write}, exp_ctrl);
      end
      checks++;
      if (rd_data !== m_rd) begin
        errors++;
        $display("FAIL rand_rd_data n=%0d got %h want %h", n, rd_data, m_rd);
      end
      if (acc) begin
        checks++;
        if (ram_addr !== m_addr || ram_wdata !== m_wdata) begin
          errors++;
          $display("FAIL rand_bus n=%0d got addr=%h wdata=%h want %h %h",
                   n, ram_addr, ram_wdata, m_addr, m_wdata);
        end
      end
    end
    settle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hB7;
    idle_inputs();
    model_reset();
    ram_clear = 1'b1;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    ram_clear = 1'b0;
    test_cpu_read();
    test_both();
    test_ldr_write();
    test_lock();
    test_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
